mb8_share_ctrl: RTL
===================

# mb8_share_ctrl

Round-robin issue controller that shares one pipelined radix-8 Booth multiplier (operand/select registers plus product register, fixed latency) among NREQ requesters. Accepts signed operand pairs over per-requester valid/ready handshakes, performs the radix-8 Booth recoding (s/d/t/q/n group selects) and the 3·Y precompute, and drives them to the multiplier through a registered issue stage. A tag pipeline tracks every in-flight operation and routes each returning product to its originating requester.

## Interface
- WIDTH, 8: operand width, signed two's complement
- NREQ, 4: number of requesters, 2..8
- LAT, 2: cycles from multiplier operand inputs to valid product
- GC: derived, (WIDTH>>2)+1, Booth group count; not overridable

- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- hold  in  1  when high, no new grants; in-flight operations continue
- req_valid  in  NREQ  request pending per requester
- req_ready  out  NREQ  one-hot grant, combinational from req_valid, pointer, hold
- req_x  in  NREQ*WIDTH  multiplier (Booth-recoded) operand, requester i at [i*WIDTH +: WIDTH]
- req_y  in  NREQ*WIDTH  multiplicand operand, same packing
- s, d, t, q, n  out  GC each  registered Booth selects to the multiplier
- my  out  WIDTH  registered multiplicand
- tmy  out  WIDTH+2  registered 3·my, sign-extended
- product  in  2*WIDTH  product from the multiplier
- rsp_valid  out  NREQ  one-hot, result valid for requester i, 1-cycle pulse
- rsp_product  out  2*WIDTH  registered result
- inflight  out  3  operations issued and not yet returned (0..LAT+1)

## Operation
- Arbitration: round-robin over requesters with req_valid=1, starting at pointer rr (reset 0). Grant g: the first i ≥ rr (wrapping) with req_valid[i]. Handshake at a clock edge where req_valid[i] & req_ready[i]. After a grant, rr ← (g+1) mod NREQ; with no grant, rr holds.
- hold=1 or RST=1: req_ready = 0.
- Booth recoding of granted x: sign-extend to 3·GC bits, x[-1]=0. Group k uses b3=x[3k+2], b2=x[3k+1], b1=x[3k], b0=x[3k-1]; v = -4·b3 + 2·b2 + b1 + b0. Outputs one-hot magnitude: s=(|v|=1), d=(|v|=2), t=(|v|=3), q=(|v|=4); n=(v<0). For v=0 all five bits are 0.
- tmy = 3·y computed at full WIDTH+2 width; never overflows.
- Issue stage: on a handshake, registers s/d/t/q/n/my/tmy and tag {valid=1, id=g}. With no handshake, selects and operands hold their last values (multiplier output ignored), and the tag valid bit is 0.
- Tag pipeline: LAT-deep shift register of {valid, id}, advanced every cycle and not stalled by hold. When the tag emerges valid, rsp_product ← product and rsp_valid ← onehot(id) at the next edge.
- inflight increments on handshake, decrements on rsp_valid issue; both in the same cycle leaves it unchanged.

## Timing
- Handshake at edge E0 → selects on outputs after E0 → rsp_valid pulse after edge E0+LAT+1 (total latency LAT+1 = 3 cycles at default).
- Throughput: one operation per cycle sustained; no bubbles between back-to-back grants.
- Response ordering equals grant ordering.
- No response backpressure; requesters must accept rsp_valid in the cycle it asserts.
- Reset values: s=d=t=q=n=0, my=0, tmy=0, rsp_valid=0, rsp_product=0, inflight=0, rr=0, all tag valid bits 0.
- Reset mid-operation: all in-flight operations are discarded; no rsp_valid ever asserts for them. The first grant after RST deasserts goes to the lowest-indexed valid requester.
- hold asserted with operations in flight: they complete normally; inflight drains to 0.

## Test plan
- Single op, WIDTH=8: requester 2, x=3, y=5 → t=3'b001, s=d=q=n=0, my=5, tmy=15; rsp_valid=4'b0100 with rsp_product=15 exactly 3 cycles after handshake.
- Recoding edges: x=-1 → s=001, n=001; x=-128 → d=100, n=100; x=0 → all selects 0. With y=-7 the products are 7, 896, and 0 respectively.
- Fairness: all four req_valid held high for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; one rsp per cycle in the same order, and inflight peaks at 3.
- Sparse: only requesters 1 and 3 valid, rr=2 → grant 3 then 1, then 3.
- hold: assert hold with 2 operations in flight → req_ready=0 throughout, both responses still arrive, inflight reaches 0.
- Reset mid-flight: RST for 1 cycle one cycle after a grant → no rsp_valid pulse afterward; all outputs read reset values; the next grant goes to the lowest-indexed valid requester.

Source files
------------

// File: rtl/mb8_share_ctrl.sv
// mb8_share_ctrl: round-robin issue front end for a shared
// pipelined radix-8 Booth multiplier with tagged returns.
module mb8_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [(WIDTH>>2):0]   s,
  output logic [(WIDTH>>2):0]   d,
  output logic [(WIDTH>>2):0]   t,
  output logic [(WIDTH>>2):0]   q,
  output logic [(WIDTH>>2):0]   n,
  output logic [WIDTH-1:0]      my,
  output logic [WIDTH+1:0]      tmy,
  input  logic [2*WIDTH-1:0]    product,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [2:0]            inflight
);

  localparam int GC = (WIDTH >> 2) + 1;
  localparam int IW = $clog2(NREQ);
  localparam int XW = 3 * GC;

  logic [IW-1:0]    rr;
  logic [IW-1:0]    gid;
  logic             found;
  logic             hs;
  logic [WIDTH-1:0] gx;
  logic [WIDTH-1:0] gy;
  logic [XW:0]      xe;
  logic [GC-1:0]    s_n;
  logic [GC-1:0]    d_n;
  logic [GC-1:0]    t_n;
  logic [GC-1:0]    q_n;
  logic [GC-1:0]    n_n;
  logic [WIDTH+1:0] ye;
  logic [WIDTH+1:0] tmy_n;
  logic             iv;
  logic [IW-1:0]    iid;
  logic [LAT-1:0]   pv;
  logic [IW-1:0]    pid [LAT];
  logic [NREQ-1:0]  oh;

  always_comb begin
    found     = 1'b0;
    gid       = rr;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found &&
          req_valid[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        gid   = IW'((int'(rr) + k) % NREQ);
      end
    end
    if (found && !hold && !RST)
      req_ready[gid] = 1'b1;
  end

  assign hs = |req_ready;
  assign gx = req_x[int'(gid)*WIDTH +: WIDTH];
  assign gy = req_y[int'(gid)*WIDTH +: WIDTH];

  // xe[0] is the implicit x[-1]; upper bits sign-extend x
  always_comb begin
    xe = '0;
    for (int b = 0; b < XW; b++)
      xe[b+1] = gx[(b < WIDTH) ? b : WIDTH-1];
  end

  always_comb begin
    s_n = '0;
    d_n = '0;
    t_n = '0;
    q_n = '0;
    n_n = '0;
    for (int k = 0; k < GC; k++) begin
      unique case (xe[3*k +: 4])
        4'b0001, 4'b0010: s_n[k] = 1'b1;
        4'b0011, 4'b0100: d_n[k] = 1'b1;
        4'b0101, 4'b0110: t_n[k] = 1'b1;
        4'b0111:          q_n[k] = 1'b1;
        4'b1000: begin
          q_n[k] = 1'b1;
          n_n[k] = 1'b1;
        end
        4'b1001, 4'b1010: begin
          t_n[k] = 1'b1;
          n_n[k] = 1'b1;
        end
        4'b1011, 4'b1100: begin
          d_n[k] = 1'b1;
          n_n[k] = 1'b1;
        end
        4'b1101, 4'b1110: begin
          s_n[k] = 1'b1;
          n_n[k] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ye    = {{2{gy[WIDTH-1]}}, gy};
  assign tmy_n = (ye << 1) + ye;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s   <= '0;
      d   <= '0;
      t   <= '0;
      q   <= '0;
      n   <= '0;
      my  <= '0;
      tmy <= '0;
      iv  <= 1'b0;
      iid <= '0;
    end else begin
      iv <= hs;
      if (hs) begin
        s   <= s_n;
        d   <= d_n;
        t   <= t_n;
        q   <= q_n;
        n   <= n_n;
        my  <= gy;
        tmy <= tmy_n;
        iid <= gid;
      end
    end
  end

  // tag shift runs free so returns line up with the fixed-latency product
  always_ff @(posedge CLK) begin
    if (RST) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++)
        pid[i] <= '0;
    end else begin
      pv[0]  <= iv;
      pid[0] <= iid;
      for (int i = 1; i < LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  always_comb begin
    oh             = '0;
    oh[pid[LAT-1]] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid   <= '0;
      rsp_product <= '0;
    end else begin
      rsp_valid <= pv[LAT-1] ? oh : '0;
      if (pv[LAT-1])
        rsp_product <= product;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= '0;
    end else begin
      unique case ({hs, pv[LAT-1]})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      rr <= '0;
    else if (hs)
      rr <= (int'(gid) == NREQ-1) ? '0 : gid + 1'b1;
  end

endmodule
